// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (fetch / data) arbiter and sequencer for a single
//            shared memory port. Data stage has priority; a streak counter
//            forces a fetch grant after MAX_DM_STREAK consecutive data grants
//            taken while fetch was waiting.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  logic [1:0]  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        err_q, err_d;

  logic        grant_dm;
  logic [15:0] sel_addr;
  logic [15:0] rd_word;

  // Arbitration: data wins unless fetch is waiting and the data streak is used up.
  assign grant_dm = dm_req && (!if_req || (streak_q < STREAK_MAX));
  assign sel_addr = grant_dm ? dm_addr : if_addr;
  // Writes return zero to the requester.
  assign rd_word  = mem_wr_q ? 16'h0000 : mem_rdata;

  // Next-state, grant, streak and output-register computation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = 16'h0000;
    dm_rdata_d  = 16'h0000;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Fetch not waiting: the streak restarts.
        if (!if_req) begin
          streak_d = 4'd0;
        end
        if (dm_req || if_req) begin
          gnt_d       = grant_dm;
          mem_addr_d  = sel_addr;
          mem_wr_d    = grant_dm & dm_wr;
          mem_wdata_d = grant_dm ? dm_wdata : 16'h0000;
          // A data grant with fetch waiting can only happen below the limit,
          // so the increment never exceeds STREAK_MAX.
          if (grant_dm) begin
            if (if_req) begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            streak_d = 4'd0;
          end
          if (sel_addr[0]) begin
            // Misaligned: answer immediately with err, no memory access.
            state_d   = S_RESP;
            if_done_d = ~grant_dm;
            dm_done_d = grant_dm;
            err_d     = 1'b1;
          end else begin
            state_d  = S_ISSUE;
            mem_en_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          state_d    = S_RESP;
          if_done_d  = ~gnt_q;
          dm_done_d  = gnt_q;
          if_rdata_d = gnt_q ? 16'h0000 : rd_word;
          dm_rdata_d = gnt_q ? rd_word : 16'h0000;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      streak_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= 16'h0000;
      dm_rdata_q  <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter. Transaction-level reference
//            model predicts the winner, memory issue and response per round.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int MAX = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int streak_m = 0;

  mem_arbiter #(.MAX_DM_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if ($urandom_range(0, 5) != 0) a[0] = 1'b0;
    return a;
  endfunction

  task automatic chk_done(input int owner, input logic [15:0] exp_rd, input logic exp_err);
    if (owner == 1) begin
      chk("dm_done", dm_done, 1);
      chk("dm_rdata", dm_rdata, exp_rd);
      chk("dm_stall_at_done", dm_stall, 0);
      chk("if_done_other", if_done, 0);
      chk("if_stall_other", if_stall, if_req);
    end else begin
      chk("if_done", if_done, 1);
      chk("if_rdata", if_rdata, exp_rd);
      chk("if_stall_at_done", if_stall, 0);
      chk("dm_done_other", dm_done, 0);
      chk("dm_stall_other", dm_stall, dm_req);
    end
    chk("err", err, exp_err);
  endtask

  // Entered just after the rising edge that starts an IDLE cycle with the
  // request inputs already driven; leaves just after the rising edge that
  // starts the next IDLE cycle.
  task automatic round(input int lat, input logic [15:0] rv, output int owner);
    logic [15:0] a;
    logic [15:0] wd;
    logic        w;
    owner = -1;
    @(negedge clk);
    chk("idle_mem_en", mem_en, 0);
    chk("idle_dones", {if_done, dm_done}, 0);
    chk("idle_if_stall", if_stall, if_req);
    chk("idle_dm_stall", dm_stall, dm_req);
    if (!if_req && !dm_req) begin
      streak_m = 0;
      mem_done = 1'b1;  // stray completion while idle must be ignored
      @(posedge clk); #1;
      mem_done = 1'b0;
    end else begin
      if (dm_req && (!if_req || streak_m < MAX)) begin
        owner = 1;
        streak_m = if_req ? streak_m + 1 : 0;
        a = dm_addr; w = dm_wr; wd = dm_wdata;
      end else begin
        owner = 0;
        streak_m = 0;
        a = if_addr; w = 1'b0; wd = 16'h0000;
      end
      @(posedge clk); #1;
      @(negedge clk);
      if (a[0]) begin
        chk("mis_mem_en", mem_en, 0);
        chk_done(owner, 16'h0000, 1'b1);
      end else begin
        chk("iss_mem_en", mem_en, 1);
        chk("iss_addr", mem_addr, a);
        chk("iss_wr", mem_wr, w);
        if (w) chk("iss_wdata", mem_wdata, wd);
        chk("iss_dones", {if_done, dm_done}, 0);
        for (int i = 1; i <= lat; i++) begin
          @(posedge clk); #1;
          if (i == lat) begin
            mem_done  = 1'b1;
            mem_rdata = rv;
          end
          @(negedge clk);
          chk("wait_mem_en", mem_en, 0);
          chk("wait_dones", {if_done, dm_done}, 0);
        end
        @(posedge clk); #1;
        mem_done  = 1'b0;
        mem_rdata = 16'($urandom);
        @(negedge clk);
        chk_done(owner, w ? 16'h0000 : rv, 1'b0);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int o;
    logic [9:0] seq;
    logic [9:0] exp_seq;

    rst = 1'b0; if_req = 1'b0; if_addr = 16'h0; dm_req = 1'b0; dm_wr = 1'b0;
    dm_addr = 16'h0; dm_wdata = 16'h0; mem_rdata = 16'h0; mem_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b1;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_dones", {if_done, dm_done}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_if_stall", if_stall, 1);
    chk("rst_dm_stall", dm_stall, 0);
    if_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only, memory answers two cycles after issue
    if_req = 1'b1; if_addr = 16'h0010;
    round(2, 16'h1234, o);
    chk("fetch_owner", 16'(o), 0);
    if_req = 1'b0;

    // Simultaneous: data write first, then the waiting fetch
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
    round(1, 16'h5555, o);
    chk("simul_first_owner", 16'(o), 1);
    dm_req = 1'b0;
    round(3, 16'hA0A0, o);
    chk("simul_second_owner", 16'(o), 0);
    if_req = 1'b0;

    // Misaligned data read
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0003;
    round(1, 16'h7777, o);
    chk("mis_owner", 16'(o), 1);
    dm_req = 1'b0;

    // Idle rounds with stray mem_done
    repeat (3) round(1, 16'h0, o);

    // Reset while waiting for memory
    if_req = 1'b1; if_addr = 16'h0080;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_mem_en", mem_en, 0);
    chk("rstw_mem_wr", mem_wr, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_dones", {if_done, dm_done}, 0);
    chk("rstw_rdata", if_rdata | dm_rdata, 0);
    chk("rstw_err", err, 0);
    chk("rstw_if_stall", if_stall, 1);
    if_req = 1'b0;
    @(negedge clk) rst = 1'b1;
    streak_m = 0;
    @(posedge clk); #1;
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_done = 1'b0;
    @(negedge clk);
    chk("stray_dones", {if_done, dm_done}, 0);
    chk("stray_mem_en", mem_en, 0);
    @(posedge clk); #1;

    // Starvation guard: fetch must win every fifth grant
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_wr = 1'b0;
    seq = '0;
    for (int k = 0; k < 10; k++) begin
      dm_addr = 16'($urandom) & 16'hFFFE;
      round(1, 16'($urandom), o);
      seq[k] = (o == 1);
    end
    exp_seq = 10'b0111101111;
    chk("starve_seq", {6'b0, seq}, {6'b0, exp_seq});
    if_req = 1'b0; dm_req = 1'b0;

    // Randomized traffic against the model
    for (int r = 0; r < 80; r++) begin
      round($urandom_range(1, 4), 16'($urandom), o);
      if (o == 1 || !dm_req) begin
        dm_req   = ($urandom_range(0, 3) != 0);
        dm_wr    = 1'($urandom);
        dm_addr  = rand_addr();
        dm_wdata = 16'($urandom);
      end
      if (o == 0 || !if_req) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = rand_addr();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single shared memory port behind the fetch and memory stages. It accepts word requests from instruction fetch (read-only) and from the data-memory stage (read/write), grants one at a time, and drives a multi-cycle memory handshake. It returns read data, a one-cycle done pulse and a stall to each requester. The data stage has priority, and a streak limit prevents fetch starvation.

## Interface
Parameters:
- MAX_DM_STREAK, 4: consecutive data grants allowed while if_req is pending before fetch is forced a grant (range 1-15).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  16  fetch byte address; stable while if_req is high.
- if_rdata  out  16  fetched word; valid only while if_done is high.
- if_done  out  1  one-cycle completion pulse to fetch.
- if_stall  out  1  if_req & ~if_done (combinational).
- dm_req  in  1  data request; held until dm_done.
- dm_wr  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  16  data byte address; stable while dm_req is high.
- dm_wdata  in  16  write data; stable while dm_req is high.
- dm_rdata  out  16  read word; valid only while dm_done is high. 0 for writes.
- dm_done  out  1  one-cycle completion pulse to data stage.
- dm_stall  out  1  dm_req & ~dm_done (combinational).
- mem_en  out  1  one-cycle issue pulse to memory.
- mem_wr  out  1  write strobe, qualified by mem_en.
- mem_addr  out  16  memory address, qualified by mem_en.
- mem_wdata  out  16  memory write data, qualified by mem_en.
- mem_rdata  in  16  memory read data, valid with mem_done.
- mem_done  in  1  memory completion pulse, at least one cycle after mem_en.
- err  out  1  misaligned-address flag, pulses together with the done of the offending request.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. A registered grant bit `gnt` (0 = fetch, 1 = data) selects the owner.
- IDLE:
  - No request: stay in IDLE.
  - If dm_req is high and either if_req is low or streak < MAX_DM_STREAK: set gnt = 1.
  - Else if if_req is high: set gnt = 0.
  - On any grant, latch the owner's addr, wr and wdata. Fetch always latches wr = 0.
  - Aligned address (addr[0] = 0): go to ISSUE.
  - Misaligned address: go directly to RESP with err set and rdata = 0. No memory access occurs.
- ISSUE: drive mem_en = 1 with the latched mem_wr, mem_addr and mem_wdata for exactly one cycle, then go to WAIT.
- WAIT: hold until mem_done. On mem_done, capture mem_rdata (capture 0 for a write) and go to RESP.
- RESP: pulse the owner's done for one cycle with its rdata (and err if set), then go to IDLE. Requests are not sampled in RESP.
- Streak counter (4-bit):
  - Increments, saturating at MAX_DM_STREAK, on a data grant while if_req is high.
  - Clears on a fetch grant, and on any IDLE cycle with if_req low.
- mem_done outside WAIT is ignored.
- mem_addr, mem_wr and mem_wdata hold their latched values outside ISSUE. They are meaningful only with mem_en.

## Timing
- Reset (rst low, asynchronous): state = IDLE, gnt = 0, streak = 0.
  - Every registered output is 0: mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, err.
  - Stall outputs follow their req inputs.
- Reset mid-operation: any in-flight access is abandoned with no done pulse. The memory must tolerate an abandoned access.
- Aligned access, request sampled at edge 0:
  - mem_en is high in cycle 1.
  - mem_done arrives in cycle k ≥ 2.
  - done is high in cycle k+1.
  - Minimum latency is 3 cycles from request to done.
- Misaligned access: done and err are high in cycle 1.
- Throughput: the next grant is sampled at the edge ending the cycle after done, giving a minimum of 4 cycles per aligned access.
- Requester rule: req is held through the done cycle. It may be dropped or replaced with a new request in the following cycle.

## Test plan
- Fetch only: if_addr = 0x0010, memory returns 0x1234 two cycles after mem_en -> mem_en in cycle 1 with mem_addr = 0x0010 and mem_wr = 0; if_done in cycle 4 with if_rdata = 0x1234; dm_done stays 0.
- Simultaneous requests: if_req = 1, dm_req = 1, dm_wr = 1, dm_addr = 0x0100, dm_wdata = 0xBEEF -> data granted first with mem_wr = 1 and mem_wdata = 0xBEEF; dm_done precedes if_done; if_stall stays high until if_done.
- Starvation: dm_req held continuously, if_req high, MAX_DM_STREAK = 4 -> exactly 4 dm_done pulses, then one if_done, then data resumes.
- Misaligned: dm_addr = 0x0003 -> dm_done and err high in cycle 1; mem_en never asserts; dm_rdata = 0.
- Reset during WAIT: rst low for 1 cycle, then a late mem_done -> no done pulse; all outputs 0; the stray mem_done is ignored; the next request completes normally.
- Spurious mem_done in IDLE -> no state change and no done pulse.
